// File: rtl/responder_arbiter.sv
// Quiz responder front-end: button conditioning, first-press arbitration,
// countdown timer control and winner / foul reporting.
module responder_arbiter #(
    parameter int N_PLAYERS   = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int BUZZ_CYCLES = 12_500_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_PLAYERS-1:0] Key_In,
    input  logic                 Host_Start,
    input  logic                 Host_Clear,
    input  logic                 Block_Sel,
    output logic                 Timer_Start,
    output logic                 Timer_RSTn,
    output logic [3:0]           Winner_ID,
    output logic [N_PLAYERS-1:0] Winner_LED,
    output logic                 Foul_LED,
    output logic                 Buzzer_Ring
);

    localparam int NB = N_PLAYERS + 2;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
    localparam logic [3:0]    ID_BLANK  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOCKED,
        S_FOUL,
        S_TIMEOUT
    } state_t;

    state_t              state;
    logic [NB-1:0]       raw_n;
    logic [NB-1:0]       sync1;
    logic [NB-1:0]       sync2;
    logic [NB-1:0]       deb_lvl;
    logic [NB-1:0]       press;
    logic [DW-1:0]       deb_cnt [NB];
    logic [1:0]          blk_sync;
    logic [BW-1:0]       buzz_cnt;
    logic [N_PLAYERS-1:0] key_ev;
    logic                start_ev;
    logic                clr_ev;
    logic                any_key;
    logic [3:0]          win_id;
    logic [N_PLAYERS-1:0] win_oh;

    assign raw_n    = {Host_Clear, Host_Start, Key_In};
    assign key_ev   = press[N_PLAYERS-1:0];
    assign start_ev = press[N_PLAYERS];
    assign clr_ev   = press[N_PLAYERS+1];
    assign any_key  = |key_ev;

    // Two-stage synchronisers for the buttons (released = high) and time-over flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1    <= '1;
            sync2    <= '1;
            blk_sync <= '0;
        end else begin
            sync1    <= raw_n;
            sync2    <= sync1;
            blk_sync <= {blk_sync[0], Block_Sel};
        end
    end

    // Per-button debouncer; deb_lvl is 1 when pressed, press pulses on accept of a press
    always_ff @(posedge CLK) begin
        if (RST) begin
            deb_lvl <= '0;
            press   <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                press[i] <= 1'b0;
                if (~sync2[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_lvl[i] <= ~sync2[i];
                        press[i]   <= ~sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Lowest-index player among simultaneous presses wins
    always_comb begin
        win_id = ID_BLANK;
        win_oh = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (key_ev[i]) begin
                win_id    = 4'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered outputs and buzzer pulse timer
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            Timer_Start <= 1'b0;
            Timer_RSTn  <= 1'b0;
            Winner_ID   <= ID_BLANK;
            Winner_LED  <= '0;
            Foul_LED    <= 1'b0;
            Buzzer_Ring <= 1'b0;
            buzz_cnt    <= '0;
        end else begin
            if (buzz_cnt != '0) buzz_cnt <= buzz_cnt - 1'b1;
            else                Buzzer_Ring <= 1'b0;

            if (clr_ev) begin
                state       <= S_IDLE;
                Timer_Start <= 1'b0;
                Timer_RSTn  <= 1'b0;
                Winner_ID   <= ID_BLANK;
                Winner_LED  <= '0;
                Foul_LED    <= 1'b0;
                Buzzer_Ring <= 1'b0;
                buzz_cnt    <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (any_key) begin
                            state       <= S_FOUL;
                            Timer_Start <= 1'b0;
                            Timer_RSTn  <= 1'b0;
                            Winner_ID   <= win_id;
                            Winner_LED  <= win_oh;
                            Foul_LED    <= 1'b1;
                            Buzzer_Ring <= 1'b1;
                            buzz_cnt    <= BUZZ_LAST;
                        end else if (start_ev) begin
                            state       <= S_ARMED;
                            Timer_Start <= 1'b1;
                            Timer_RSTn  <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (blk_sync[1]) begin
                            state       <= S_TIMEOUT;
                            Timer_Start <= 1'b0;
                            Timer_RSTn  <= 1'b1;
                        end else if (any_key) begin
                            state       <= S_LOCKED;
                            Timer_Start <= 1'b0;
                            Timer_RSTn  <= 1'b1;
                            Winner_ID   <= win_id;
                            Winner_LED  <= win_oh;
                            Buzzer_Ring <= 1'b1;
                            buzz_cnt    <= BUZZ_LAST;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_responder_arbiter.sv
// Scoreboard bench for responder_arbiter: expected output bundles and the
// cycle they must appear in are queued by stimulus and checked by a monitor.
module tb_responder_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] Key_In;
    logic       Host_Start;
    logic       Host_Clear;
    logic       Block_Sel;
    logic       Timer_Start;
    logic       Timer_RSTn;
    logic [3:0] Winner_ID;
    logic [3:0] Winner_LED;
    logic       Foul_LED;
    logic       Buzzer_Ring;

    typedef struct packed {
        int          cyc;
        logic [11:0] b;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] bundle;

    responder_arbiter #(
        .N_PLAYERS  (4),
        .DEB_CYCLES (4),
        .BUZZ_CYCLES(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Key_In     (Key_In),
        .Host_Start (Host_Start),
        .Host_Clear (Host_Clear),
        .Block_Sel  (Block_Sel),
        .Timer_Start(Timer_Start),
        .Timer_RSTn (Timer_RSTn),
        .Winner_ID  (Winner_ID),
        .Winner_LED (Winner_LED),
        .Foul_LED   (Foul_LED),
        .Buzzer_Ring(Buzzer_Ring)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign bundle = {Timer_Start, Timer_RSTn, Winner_ID, Winner_LED,
                     Foul_LED, Buzzer_Ring};

    function automatic logic [11:0] mk(input logic ts, input logic tr,
                                       input logic [3:0] id,
                                       input logic [3:0] led,
                                       input logic f, input logic bz);
        return {ts, tr, id, led, f, bz};
    endfunction

    localparam logic [11:0] B_IDLE  = {1'b0, 1'b0, 4'd10, 4'b0000, 1'b0, 1'b0};
    localparam logic [11:0] B_ARMED = {1'b1, 1'b1, 4'd10, 4'b0000, 1'b0, 1'b0};
    localparam logic [11:0] B_TOUT  = {1'b0, 1'b1, 4'd10, 4'b0000, 1'b0, 1'b0};

    // Monitor: every change of the output bundle must match the next queued entry
    initial begin
        exp_t        e;
        logic [11:0] prev;
        prev = 'x;
        forever begin
            @(negedge CLK);
            if (bundle !== prev) begin
                prev = bundle;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b", cyc, bundle);
                end else begin
                    e = q.pop_front();
                    if (bundle !== e.b || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL bundle_change got=%b@%0d exp=%b@%0d",
                                 bundle, cyc, e.b, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_at(input int dc, input logic [11:0] b);
        exp_t e;
        e.cyc = cyc + dc;
        e.b   = b;
        q.push_back(e);
    endtask

    task automatic do_start();
        exp_at(7, B_ARMED);
        Host_Start = 1'b0;
        tick(6);
        Host_Start = 1'b1;
        tick(12);
    endtask

    task automatic do_clear(input logic [11:0] b_after);
        exp_at(7, b_after);
        Host_Clear = 1'b0;
        tick(6);
        Host_Clear = 1'b1;
        tick(12);
    endtask

    task automatic do_keys(input logic [3:0] k);
        Key_In = k;
        tick(6);
        Key_In = 4'hF;
        tick(12);
    endtask

    initial begin
        RST        = 1'b1;
        Key_In     = 4'hF;
        Host_Start = 1'b1;
        Host_Clear = 1'b1;
        Block_Sel  = 1'b0;
        exp_at(1, B_IDLE);
        tick(3);
        RST = 1'b0;
        tick(4);

        // Arm, then player 3 locks; player 1 afterwards is ignored
        do_start();
        exp_at(7, mk(1'b0, 1'b1, 4'd3, 4'b0100, 1'b0, 1'b1));
        exp_at(15, mk(1'b0, 1'b1, 4'd3, 4'b0100, 1'b0, 1'b0));
        do_keys(4'b1011);
        do_keys(4'b1110);
        do_clear(B_IDLE);

        // Simultaneous players 1 and 3: lowest index wins
        do_start();
        exp_at(7, mk(1'b0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b1));
        exp_at(15, mk(1'b0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b0));
        do_keys(4'b1010);
        do_clear(B_IDLE);

        // False start by player 2 in IDLE
        exp_at(7, mk(1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b1));
        exp_at(15, mk(1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0));
        do_keys(4'b1101);
        do_keys(4'b1110);
        do_clear(B_IDLE);

        // Time over while armed; presses ignored afterwards
        do_start();
        exp_at(3, B_TOUT);
        Block_Sel = 1'b1;
        tick(6);
        do_keys(4'b0111);
        Block_Sel = 1'b0;
        do_clear(B_IDLE);

        // Bouncing key never produces an event
        do_start();
        for (int i = 0; i < 4; i++) begin
            Key_In[3] = 1'b0;
            tick(1);
            Key_In[3] = 1'b1;
            tick(1);
        end
        tick(12);

        // Lock, then clear lands mid-buzz
        exp_at(7, mk(1'b0, 1'b1, 4'd1, 4'b0001, 1'b0, 1'b1));
        exp_at(10, B_IDLE);
        Key_In = 4'b1110;
        tick(3);
        Host_Clear = 1'b0;
        tick(3);
        Key_In = 4'hF;
        tick(3);
        Host_Clear = 1'b1;
        tick(15);

        // Start and clear together while armed: clear wins; in IDLE nothing moves
        do_start();
        exp_at(7, B_IDLE);
        Host_Start = 1'b0;
        Host_Clear = 1'b0;
        tick(6);
        Host_Start = 1'b1;
        Host_Clear = 1'b1;
        tick(12);
        Host_Start = 1'b0;
        Host_Clear = 1'b0;
        tick(6);
        Host_Start = 1'b1;
        Host_Clear = 1'b1;
        tick(20);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations left=%0d required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
